mesi_isc_nway: RTL

Parametrised MESI intersystem coherence controller serving `CPU_COUNT` CPUs, the next generation of the fixed four-CPU controller. It accepts write/read broadcast requests from each CPU's main bus into per-CPU request FIFOs and arbitrates them round-robin into a shared broadcast FIFO. A broadcast engine snoops every other CPU on its coherence bus, collects their acks, then grants the originator.

---
 rtl/mesi_isc_nway.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/mesi_isc_nway.sv
// mesi_isc_nway: N-CPU MESI broadcast coherence controller. Per-CPU request
// FIFOs feed a round-robin arbiter into a shared broadcast FIFO, which a
// snoop/enable engine drains one broadcast at a time.
module mesi_isc_nway #(
    parameter int unsigned CPU_COUNT            = 4,
    parameter int unsigned CPU_ID_WIDTH         = 2,
    parameter int unsigned MBUS_CMD_WIDTH       = 3,
    parameter int unsigned CBUS_CMD_WIDTH       = 3,
    parameter int unsigned ADDR_WIDTH           = 32,
    parameter int unsigned BROAD_ID_WIDTH       = 5,
    parameter int unsigned BREQ_FIFO_SIZE       = 2,
    parameter int unsigned BREQ_FIFO_SIZE_LOG2  = 1,
    parameter int unsigned BROAD_FIFO_SIZE      = 4,
    parameter int unsigned BROAD_FIFO_SIZE_LOG2 = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CPU_COUNT*MBUS_CMD_WIDTH-1:0] mbus_cmd_array_i,
    input  logic [CPU_COUNT*ADDR_WIDTH-1:0]     mbus_addr_array_i,
    input  logic [CPU_COUNT-1:0]                cbus_ack_array_i,
    output logic [CPU_COUNT-1:0]                mbus_ack_array_o,
    output logic [ADDR_WIDTH-1:0]               cbus_addr_o,
    output logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
    output logic [BROAD_ID_WIDTH-1:0]           broad_id_o,
    output logic                                busy_o
);
    localparam int unsigned BqPw = (BREQ_FIFO_SIZE_LOG2 > 0) ? BREQ_FIFO_SIZE_LOG2 : 1;
    localparam int unsigned BqCw = BqPw + 1;
    localparam int unsigned BfPw = (BROAD_FIFO_SIZE_LOG2 > 0) ? BROAD_FIFO_SIZE_LOG2 : 1;
    localparam int unsigned BfCw = BfPw + 1;
    localparam int unsigned BqW  = 1 + ADDR_WIDTH;
    localparam int unsigned BfW  = BqW + CPU_ID_WIDTH + BROAD_ID_WIDTH;

    localparam logic [MBUS_CMD_WIDTH-1:0] MbusWrBroad = MBUS_CMD_WIDTH'(3);
    localparam logic [MBUS_CMD_WIDTH-1:0] MbusRdBroad = MBUS_CMD_WIDTH'(4);
    localparam logic [CBUS_CMD_WIDTH-1:0] CbusWrSnoop = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CbusRdSnoop = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CbusEnWr    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CbusEnRd    = CBUS_CMD_WIDTH'(4);

    typedef enum logic [1:0] {StIdle, StSnoop, StEnable} state_e;

    // Request FIFOs: entry is {is_rd, addr}.
    logic [CPU_COUNT-1:0] mbus_ack_q, breq_push, breq_pop, breq_empty, arb_pick;
    logic [BqPw-1:0]      breq_wr_q [CPU_COUNT];
    logic [BqPw-1:0]      breq_rd_q [CPU_COUNT];
    logic [BqCw-1:0]      breq_cnt_q[CPU_COUNT];
    logic [BqW-1:0]       breq_din  [CPU_COUNT];
    logic [BqW-1:0]       breq_mem_q[CPU_COUNT][BREQ_FIFO_SIZE];

    // Broadcast FIFO: entry is {is_rd, addr, cpu_id, tag}.
    logic [BfPw-1:0]           broad_wr_q, broad_rd_q;
    logic [BfCw-1:0]           broad_cnt_q;
    logic [BfW-1:0]            broad_mem_q[BROAD_FIFO_SIZE];
    logic [BfW-1:0]            broad_head;
    logic                      broad_full, broad_empty, broad_pop, arb_found, arb_push;
    logic [BqW-1:0]            arb_entry;
    logic [CPU_ID_WIDTH-1:0]   arb_id, rr_q;
    logic [BROAD_ID_WIDTH-1:0] tag_q;

    // Broadcast engine.
    state_e                           state_q, state_d;
    logic [CPU_COUNT-1:0]             done_q, done_d;
    logic [CPU_ID_WIDTH-1:0]          origin_q;
    logic                             is_rd_q;
    logic [ADDR_WIDTH-1:0]            addr_q;
    logic [BROAD_ID_WIDTH-1:0]        id_q;
    logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0] cbus_cmd;

    function automatic logic [BqPw-1:0] bq_inc(input logic [BqPw-1:0] p);
        return (p == BqPw'(BREQ_FIFO_SIZE - 1)) ? '0 : p + BqPw'(1);
    endfunction

    function automatic logic [BfPw-1:0] bf_inc(input logic [BfPw-1:0] p);
        return (p == BfPw'(BROAD_FIFO_SIZE - 1)) ? '0 : p + BfPw'(1);
    endfunction

    assign broad_full  = (broad_cnt_q == BfCw'(BROAD_FIFO_SIZE));
    assign broad_empty = (broad_cnt_q == '0);
    assign broad_head  = broad_mem_q[broad_rd_q];

    // Accept decode per CPU, then round-robin pick starting after the last winner.
    always_comb begin
        for (int c = 0; c < CPU_COUNT; c++) begin
            logic [MBUS_CMD_WIDTH-1:0] cmd;
            cmd           = mbus_cmd_array_i[c*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
            breq_empty[c] = (breq_cnt_q[c] == '0);
            // A full FIFO blocks even if it pops this edge; ack cycle blocks re-accept.
            breq_push[c]  = ((cmd == MbusWrBroad) || (cmd == MbusRdBroad)) && !mbus_ack_q[c] &&
                            (breq_cnt_q[c] != BqCw'(BREQ_FIFO_SIZE));
            breq_din[c]   = {cmd == MbusRdBroad, mbus_addr_array_i[c*ADDR_WIDTH +: ADDR_WIDTH]};
        end
        arb_pick  = '0;
        arb_found = 1'b0;
        arb_id    = '0;
        arb_entry = '0;
        for (int c = 0; c < CPU_COUNT; c++) begin
            if (!arb_found && c > int'(rr_q) && !breq_empty[c]) begin
                arb_found   = 1'b1;
                arb_pick[c] = 1'b1;
                arb_id      = CPU_ID_WIDTH'(c);
                arb_entry   = breq_mem_q[c][breq_rd_q[c]];
            end
        end
        for (int c = 0; c < CPU_COUNT; c++) begin
            if (!arb_found && c <= int'(rr_q) && !breq_empty[c]) begin
                arb_found   = 1'b1;
                arb_pick[c] = 1'b1;
                arb_id      = CPU_ID_WIDTH'(c);
                arb_entry   = breq_mem_q[c][breq_rd_q[c]];
            end
        end
        arb_push = arb_found && !broad_full;
        breq_pop = arb_push ? arb_pick : '0;
    end

    // Request FIFO pointers, occupancy and main-bus ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mbus_ack_q <= '0;
            for (int c = 0; c < CPU_COUNT; c++) begin
                breq_wr_q[c]  <= '0;
                breq_rd_q[c]  <= '0;
                breq_cnt_q[c] <= '0;
            end
        end else begin
            mbus_ack_q <= breq_push;
            for (int c = 0; c < CPU_COUNT; c++) begin
                if (breq_push[c]) breq_wr_q[c] <= bq_inc(breq_wr_q[c]);
                if (breq_pop[c])  breq_rd_q[c] <= bq_inc(breq_rd_q[c]);
                breq_cnt_q[c] <= breq_cnt_q[c] + BqCw'(breq_push[c]) - BqCw'(breq_pop[c]);
            end
        end
    end

    // Request FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CPU_COUNT; c++) begin
            if (breq_push[c]) breq_mem_q[c][breq_wr_q[c]] <= breq_din[c];
        end
    end

    // Broadcast FIFO pointers, round-robin pointer and tag counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            broad_wr_q  <= '0;
            broad_rd_q  <= '0;
            broad_cnt_q <= '0;
            rr_q        <= CPU_ID_WIDTH'(CPU_COUNT - 1);
            tag_q       <= '0;
        end else begin
            if (arb_push) begin
                broad_wr_q <= bf_inc(broad_wr_q);
                rr_q       <= arb_id;
                tag_q      <= tag_q + BROAD_ID_WIDTH'(1);
            end
            if (broad_pop) broad_rd_q <= bf_inc(broad_rd_q);
            broad_cnt_q <= broad_cnt_q + BfCw'(arb_push) - BfCw'(broad_pop);
        end
    end

    // Broadcast FIFO storage.
    always_ff @(posedge clk) begin
        if (arb_push) broad_mem_q[broad_wr_q] <= {arb_entry, arb_id, tag_q};
    end

    // Engine next state and coherence commands.
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        broad_pop = 1'b0;
        cbus_cmd  = '0;
        unique case (state_q)
            StIdle: begin
                if (!broad_empty) begin
                    broad_pop = 1'b1;
                    done_d    = '0;
                    state_d   = StSnoop;
                end
            end
            StSnoop: begin
                for (int c = 0; c < CPU_COUNT; c++) begin
                    if (c != int'(origin_q)) begin
                        if (!done_q[c]) begin
                            cbus_cmd[c*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
                                is_rd_q ? CbusRdSnoop : CbusWrSnoop;
                            if (cbus_ack_array_i[c]) done_d[c] = 1'b1;
                        end
                    end else begin
                        // The origin is never snooped; treat it as already done.
                        done_d[c] = 1'b1;
                    end
                end
                if (&done_d) state_d = StEnable;
            end
            StEnable: begin
                for (int c = 0; c < CPU_COUNT; c++) begin
                    if (c == int'(origin_q)) begin
                        cbus_cmd[c*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
                            is_rd_q ? CbusEnRd : CbusEnWr;
                        if (cbus_ack_array_i[c]) state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Engine state and the broadcast currently being served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            done_q   <= '0;
            origin_q <= '0;
            is_rd_q  <= 1'b0;
            addr_q   <= '0;
            id_q     <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (broad_pop) begin
                is_rd_q  <= broad_head[BfW-1];
                addr_q   <= broad_head[BfW-2 -: ADDR_WIDTH];
                origin_q <= broad_head[BROAD_ID_WIDTH +: CPU_ID_WIDTH];
                id_q     <= broad_head[BROAD_ID_WIDTH-1:0];
            end
        end
    end

    assign mbus_ack_array_o = mbus_ack_q;
    assign cbus_cmd_array_o = cbus_cmd;
    assign cbus_addr_o      = addr_q;
    assign broad_id_o       = id_q;
    assign busy_o           = (state_q != StIdle);

endmodule
